// File: rtl/text_pkg.sv
// Shared constants, FSM encoding and addressing helper for the text frame buffer.
package text_pkg;

    localparam int unsigned COLS_DEF   = 80;
    localparam int unsigned ROWS_DEF   = 25;
    localparam int unsigned CHAR_W_DEF = 8;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_CLEAR       = 2'd1;
    localparam logic [1:0] ST_SCROLL_COPY = 2'd2;
    localparam logic [1:0] ST_SCROLL_FILL = 2'd3;

    // Row-major cell index.
    function automatic int unsigned cell_addr(input int unsigned x, input int unsigned y,
                                              input int unsigned cols);
        return y * cols + x;
    endfunction

endpackage

// File: rtl/text_ram_dp.sv
// Character RAM: one write port, sequencer read port A, display/cursor read ports (read-first).
module text_ram_dp #(
    parameter int unsigned DEPTH = 2000,
    parameter int unsigned A_W   = 11,
    parameter int unsigned D_W   = 8,
    parameter logic [D_W-1:0] FILL = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           we,
    input  logic [A_W-1:0] waddr,
    input  logic [D_W-1:0] wdata,
    input  logic [A_W-1:0] a_addr,
    output logic [D_W-1:0] a_q,
    input  logic [A_W-1:0] b_addr,
    input  logic           b_ok,
    output logic [D_W-1:0] b_q,
    input  logic [A_W-1:0] c_addr,
    input  logic           c_ok,
    output logic [D_W-1:0] c_q
);

    logic [D_W-1:0] mem [DEPTH];

    // Array storage is never reset; the clear sweep initialises it.
    always_ff @(posedge clk) begin
        a_q <= mem[a_addr];
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range display/cursor coordinates read back as the fill code.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_q <= FILL;
            c_q <= FILL;
        end else begin
            b_q <= b_ok ? mem[b_addr] : FILL;
            c_q <= c_ok ? mem[c_addr] : FILL;
        end
    end

endmodule

// File: rtl/text_frame_buffer.sv
// Text-mode character frame buffer with user write port, display read port
// and an internal clear / scroll-up sequencer.
module text_frame_buffer
    import text_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned CHAR_W = CHAR_W_DEF,
    parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(ASCII_SPACE),
    parameter int unsigned X_W    = $clog2(COLS),
    parameter int unsigned Y_W    = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic [X_W-1:0]    wr_x,
    input  logic [Y_W-1:0]    wr_y,
    input  logic              clear_req,
    input  logic              scroll_req,
    input  logic [X_W-1:0]    rd_x,
    input  logic [Y_W-1:0]    rd_y,
    output logic [CHAR_W-1:0] rd_char,
    output logic [CHAR_W-1:0] cur_char,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              busy
);

    localparam int unsigned N   = COLS * ROWS;
    localparam int unsigned A_W = $clog2(N);
    localparam logic [A_W-1:0] LAST     = A_W'(N - 1);
    localparam logic [A_W-1:0] COPY_END = A_W'(N - COLS);
    localparam logic [A_W-1:0] ROW_OFF  = A_W'(COLS);

    logic [1:0]        state, state_nx;
    logic [A_W-1:0]    addr, addr_nx;
    logic              ack_nx, err_nx;
    logic              we;
    logic [A_W-1:0]    waddr, seq_raddr;
    logic [CHAR_W-1:0] wdata, seq_q;
    logic              wr_ok, rd_ok;
    logic [A_W-1:0]    wr_addr, rd_addr;

    assign wr_ok   = (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
    assign rd_ok   = (32'(rd_x) < COLS) && (32'(rd_y) < ROWS);
    assign wr_addr = A_W'(cell_addr(32'(wr_x), 32'(wr_y), COLS));
    assign rd_addr = A_W'(cell_addr(32'(rd_x), 32'(rd_y), COLS));
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_CLEAR;
            addr   <= '0;
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            state  <= state_nx;
            addr   <= addr_nx;
            wr_ack <= ack_nx;
            wr_err <= err_nx;
        end
    end

    // Sequencer and write-port arbitration.
    always_comb begin
        state_nx  = state;
        addr_nx   = addr;
        ack_nx    = 1'b0;
        err_nx    = wr_req && (state != ST_IDLE);
        we        = 1'b0;
        waddr     = '0;
        wdata     = FILL_CHAR;
        seq_raddr = '0;
        case (state)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nx = ST_CLEAR;
                    addr_nx  = '0;
                    err_nx   = wr_req;
                end else if (scroll_req) begin
                    state_nx = ST_SCROLL_COPY;
                    addr_nx  = '0;
                    err_nx   = wr_req;
                end else if (wr_req) begin
                    if (wr_ok) begin
                        we     = 1'b1;
                        waddr  = wr_addr;
                        wdata  = wr_char;
                        ack_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ST_CLEAR, ST_SCROLL_FILL: begin
                we    = 1'b1;
                waddr = addr;
                if (addr == LAST) begin
                    state_nx = ST_IDLE;
                    addr_nx  = '0;
                end else begin
                    addr_nx = addr + A_W'(1);
                end
            end
            ST_SCROLL_COPY: begin
                // Read one row ahead; last cycle's read lands one cell behind this one.
                if (addr != COPY_END) begin
                    seq_raddr = addr + ROW_OFF;
                end
                if (addr != '0) begin
                    we    = 1'b1;
                    waddr = addr - A_W'(1);
                    wdata = seq_q;
                end
                if (addr == COPY_END) begin
                    state_nx = ST_SCROLL_FILL;
                end else begin
                    addr_nx = addr + A_W'(1);
                end
            end
            default: begin
                state_nx = ST_CLEAR;
                addr_nx  = '0;
            end
        endcase
    end

    text_ram_dp #(
        .DEPTH (N),
        .A_W   (A_W),
        .D_W   (CHAR_W),
        .FILL  (FILL_CHAR)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .a_addr  (seq_raddr),
        .a_q     (seq_q),
        .b_addr  (rd_addr),
        .b_ok    (rd_ok),
        .b_q     (rd_char),
        .c_addr  (wr_addr),
        .c_ok    (wr_ok),
        .c_q     (cur_char)
    );

endmodule
